// File: rtl/ic_pkg.sv
// Shared definitions for the backup/restore controller: FSM encoding,
// per-register status bit positions and the slot index width helper.
package ic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BKP_SCAN,
    BKP_REQ,
    BKP_CAPT,
    BKP_DONE,
    RST_DRV,
    RST_DONE
  } ic_state_t;

  localparam int DIRTY_BIT = 0;
  localparam int VALID_BIT = 1;

  // A single register still needs one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ic_nv_store.sv
// Non-volatile snapshot store: N_REGS x W slots plus the snapshot_valid bit.
// Deliberately has no reset so a controller reset cannot disturb the image.
module ic_nv_store
  import ic_pkg::*;
#(
  parameter int N_REGS = 3,
  parameter int W      = 32
) (
  input  logic                         Clk,
  input  logic                         wr_en,
  input  logic [idx_width(N_REGS)-1:0] wr_idx,
  input  logic [W-1:0]                 wr_data,
  input  logic                         valid_set,
  input  logic                         valid_clr,
  input  logic [idx_width(N_REGS)-1:0] rd_idx,
  output logic [W-1:0]                 rd_data,
  output logic                         snapshot_valid
);

  logic [W-1:0] mem [N_REGS];

  // Clear beats set so a fresh backup always starts from an invalid snapshot.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (valid_clr)      snapshot_valid <= 1'b0;
    else if (valid_set) snapshot_valid <= 1'b1;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ic_backup_ctrl.sv
// Always-on backup/restore master for the wrapped pipeline registers.
// Build option IC_SKIP_CLEAN_EN: back up only registers whose dirty bit is set.
module ic_backup_ctrl
  import ic_pkg::*;
#(
  parameter int N_REGS = 3,
  parameter int W      = 32
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Pwr_warn,
  input  logic                Pwr_restore,
  input  logic                Nv_clr,
  input  logic [2*N_REGS-1:0] dirty_vals,
  output logic [N_REGS-1:0]   backup_ens,
  output logic [N_REGS-1:0]   backup_acks,
  input  logic [N_REGS*W-1:0] backup_Vouts,
  output logic [N_REGS-1:0]   restore_ens,
  output logic [N_REGS*W-1:0] restore_Vins,
  output logic                stand_by,
  output logic                Backup_done,
  output logic                Restore_done,
  output logic                Restore_err
);

  localparam int IW = idx_width(N_REGS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REGS - 1);

  ic_state_t     state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          err_q, err_nxt;
  logic          needs_backup;
  logic          st_wr_en, st_valid_set, st_valid_clr;
  logic [W-1:0]  slot_rd;
  logic          snapshot_valid;

`ifdef IC_SKIP_CLEAN_EN
  assign needs_backup = dirty_vals[2*int'(idx)+DIRTY_BIT];
`else
  logic unused_dirty;
  assign unused_dirty = ^dirty_vals;
  assign needs_backup = 1'b1;
`endif

  ic_nv_store #(.N_REGS(N_REGS), .W(W)) u_store (
    .Clk            (Clk),
    .wr_en          (st_wr_en),
    .wr_idx         (idx),
    .wr_data        (backup_Vouts[int'(idx)*W +: W]),
    .valid_set      (st_valid_set),
    .valid_clr      (st_valid_clr),
    .rd_idx         (idx),
    .rd_data        (slot_rd),
    .snapshot_valid (snapshot_valid)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      idx   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      err_q <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    err_nxt      = err_q;
    st_wr_en     = 1'b0;
    st_valid_set = 1'b0;
    st_valid_clr = 1'b0;
    backup_ens   = '0;
    backup_acks  = '0;
    restore_ens  = '0;
    restore_Vins = '0;
    stand_by     = (state != IDLE);
    Backup_done  = 1'b0;
    Restore_done = 1'b0;
    Restore_err  = 1'b0;
    case (state)
      IDLE: begin
        if (Nv_clr) st_valid_clr = 1'b1;
        if (Pwr_warn) begin
          state_nxt    = BKP_SCAN;
          idx_nxt      = '0;
          st_valid_clr = 1'b1;
        end else if (Pwr_restore) begin
          state_nxt = RST_DRV;
          idx_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      BKP_SCAN: begin
        if (needs_backup) begin
          state_nxt = BKP_REQ;
        end else if (idx == LAST_IDX) begin
          st_valid_set = 1'b1;
          state_nxt    = BKP_DONE;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      BKP_REQ: begin
        backup_ens[idx] = 1'b1;
        state_nxt       = BKP_CAPT;
      end
      BKP_CAPT: begin
        backup_acks[idx] = 1'b1;
        st_wr_en         = 1'b1;
        if (idx == LAST_IDX) begin
          st_valid_set = 1'b1;
          state_nxt    = BKP_DONE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = BKP_SCAN;
        end
      end
      BKP_DONE: begin
        Backup_done = 1'b1;
        if (!Pwr_warn) state_nxt = IDLE;
      end
      // A power warning outranks an in-flight restore; no strobe on that cycle.
      RST_DRV: begin
        if (Pwr_warn) begin
          state_nxt    = BKP_SCAN;
          idx_nxt      = '0;
          st_valid_clr = 1'b1;
        end else if (!snapshot_valid) begin
          err_nxt   = 1'b1;
          state_nxt = RST_DONE;
        end else begin
          restore_ens[idx]                 = 1'b1;
          restore_Vins[int'(idx)*W +: W]   = slot_rd;
          if (idx == LAST_IDX) state_nxt = RST_DONE;
          else                 idx_nxt   = idx + 1'b1;
        end
      end
      RST_DONE: begin
        Restore_done = 1'b1;
        Restore_err  = err_q;
        if (!Pwr_restore) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ic_backup_ctrl.sv
// Directed bench for ic_backup_ctrl in the default build (every register backed up).
module tb_ic_backup_ctrl;

  localparam int N_REGS = 3;
  localparam int W      = 32;

  logic                Clk = 1'b0;
  logic                Rst;
  logic                Pwr_warn, Pwr_restore, Nv_clr;
  logic [2*N_REGS-1:0] dirty_vals;
  logic [N_REGS-1:0]   backup_ens, backup_acks, restore_ens;
  logic [N_REGS*W-1:0] backup_Vouts, restore_Vins;
  logic                stand_by, Backup_done, Restore_done, Restore_err;

  int vectorCount = 0;
  int missCount   = 0;
  logic [W-1:0] images [N_REGS];
  logic [N_REGS*W-1:0] expVins;
  logic [N_REGS-1:0] expEns, expAcks;

  ic_backup_ctrl #(.N_REGS(N_REGS), .W(W)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Pwr_warn     (Pwr_warn),
    .Pwr_restore  (Pwr_restore),
    .Nv_clr       (Nv_clr),
    .dirty_vals   (dirty_vals),
    .backup_ens   (backup_ens),
    .backup_acks  (backup_acks),
    .backup_Vouts (backup_Vouts),
    .restore_ens  (restore_ens),
    .restore_Vins (restore_Vins),
    .stand_by     (stand_by),
    .Backup_done  (Backup_done),
    .Restore_done (Restore_done),
    .Restore_err  (Restore_err)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic warn, input logic restore, input logic clr);
    Pwr_warn    = warn;
    Pwr_restore = restore;
    Nv_clr      = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_strobes"}, {backup_ens, backup_acks, restore_ens}, '0);
    checkOutput({tag, "_flags"}, {stand_by, Backup_done, Restore_done, Restore_err}, '0);
    checkOutput({tag, "_vins"}, restore_Vins, '0);
  endtask

  initial begin
    images[0] = 32'hA5A5_A5A5;
    images[1] = 32'h0000_1234;
    images[2] = 32'h0000_0001;
    backup_Vouts = {images[2], images[1], images[0]};
    dirty_vals   = 6'b10_10_10;
    Rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkQuiet("reset");
    Rst = 1'b0;

    // Restore with no snapshot: error, no strobes
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("noimg_standby", stand_by, 1);
    checkOutput("noimg_ens0", restore_ens, 0);
    tick();
    checkOutput("noimg_ens1", restore_ens, 0);
    checkOutput("noimg_done_err", {Restore_done, Restore_err}, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("noimg_idle", {stand_by, Restore_done, Restore_err}, 3'b000);

    // Full backup; warning drops mid-sequence and must be ignored
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 3) applyStimulus(1'b0, 1'b0, 1'b0);
      expEns  = (c == 2) ? 3'b001 : (c == 5) ? 3'b010 : (c == 8) ? 3'b100 : 3'b000;
      expAcks = (c == 3) ? 3'b001 : (c == 6) ? 3'b010 : (c == 9) ? 3'b100 : 3'b000;
      checkOutput($sformatf("bkp_ens_c%0d", c), backup_ens, expEns);
      checkOutput($sformatf("bkp_acks_c%0d", c), backup_acks, expAcks);
      checkOutput($sformatf("bkp_done_c%0d", c), {stand_by, Backup_done}, {1'b1, c == 10});
    end
    tick();
    checkOutput("bkp_idle", {stand_by, Backup_done}, 2'b00);

    // Restore drives stored images one register per cycle
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < N_REGS; c++) begin
      tick();
      expVins = '0;
      expVins[c*W +: W] = images[c];
      checkOutput($sformatf("rst_ens_%0d", c), restore_ens, 3'b001 << c);
      checkOutput($sformatf("rst_vins_%0d", c), restore_Vins, expVins);
    end
    tick();
    checkOutput("rst_done", {Restore_done, Restore_err, restore_ens}, 5'b10_000);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rst_idle", {stand_by, Restore_done}, 2'b00);

    // Reset during capture of reg1 tears the snapshot
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    checkOutput("torn_ack1", backup_acks, 3'b010);
    Rst = 1'b1;
    #1;
    checkQuiet("torn_reset");
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    Rst = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("torn_ens", restore_ens, 0);
    tick();
    checkOutput("torn_err", {Restore_done, Restore_err, restore_ens}, 5'b11_000);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();

    // Fresh backup, then a warning aborts the restore at reg1
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    checkOutput("abort_bkp_done", Backup_done, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("abort_ens_idx1", restore_ens, 3'b010);
    applyStimulus(1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("abort_ens_cut", restore_ens, 0);
    tick();
    checkOutput("abort_scan", {restore_ens, backup_ens, stand_by}, 7'b000_000_1);
    tick();
    checkOutput("abort_bkp_req0", backup_ens, 3'b001);
    repeat (8) tick();
    checkOutput("abort_bkp_fin", Backup_done, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("final_idle", {stand_by, Backup_done}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
